// File: rtl/ram_track_walker_pkg.sv
// Shared types and defaults for the song-RAM track walker.
package ram_track_walker_pkg;

   localparam int unsigned DEF_ADDR_W = 26;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_REQ       = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   // The tempo prescaler only advances while waiting for, or serving, a note read.
   function automatic logic tempo_running(input state_t s);
      return (s == ST_WAIT_TICK) || (s == ST_REQ);
   endfunction

endpackage

// File: rtl/ram_track_walker_tempo_prescaler.sv
// Tempo divider: fires a tick every TICK_DIV running, unpaused cycles.
module ram_track_walker_tempo_prescaler #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic habilitador,
   input  logic reset_n,
   input  logic run,
   input  logic pause,
   input  logic reload,
   output logic tick_c
);

   localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick_c = run && !pause && (cnt == '0);

   always_ff @(posedge habilitador or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (reload || tick_c) begin
         cnt <= LOAD;
      end else if (run && !pause) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/ram_track_walker.sv
// Song-RAM address sequencer: one note read per tempo tick over a req/ack handshake.
module ram_track_walker
   import ram_track_walker_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned STEP     = 1
) (
   input  logic              habilitador,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic [ADDR_W-1:0] DireccionRAM,
   output logic              rd_req,
   input  logic              rd_ack,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] note_data,
   output logic              note_valid,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] addr_acc;
   logic              loop_q;
   logic              tick_c;
   logic              reload_c;
   logic              last_c;

   assign reload_c = (state == ST_IDLE) && start && !stop;
   assign last_c   = (offset == len_q - 1'b1);

   ram_track_walker_tempo_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .habilitador (habilitador),
      .reset_n     (reset_n),
      .run         (tempo_running(state)),
      .pause       (pause),
      .reload      (reload_c),
      .tick_c      (tick_c)
   );

   // addr_acc tracks base + offset*STEP incrementally, so no multiplier is needed.
   always_ff @(posedge habilitador or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         base_q       <= '0;
         len_q        <= '0;
         offset       <= '0;
         addr_acc     <= '0;
         loop_q       <= 1'b0;
         DireccionRAM <= '0;
         rd_req       <= 1'b0;
         note_data    <= '0;
         note_valid   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         wrapped      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         note_valid <= 1'b0;
         done       <= 1'b0;
         wrapped    <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (reload_c) begin
                  base_q   <= base_addr;
                  len_q    <= length;
                  loop_q   <= loop_en;
                  offset   <= '0;
                  addr_acc <= base_addr;
                  overrun  <= 1'b0;
                  busy     <= 1'b1;
                  if (length == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_WAIT_TICK;
                  end
               end
            end
            ST_WAIT_TICK: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (tick_c) begin
                  DireccionRAM <= addr_acc;
                  rd_req       <= 1'b1;
                  state        <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (tick_c) begin
                  overrun <= 1'b1;
               end
               if (stop) begin
                  // An ack coinciding with stop closes the handshake; its data is dropped.
                  if (rd_ack) begin
                     rd_req <= 1'b0;
                     state  <= ST_IDLE;
                     busy   <= 1'b0;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else if (rd_ack) begin
                  rd_req     <= 1'b0;
                  note_data  <= rd_data;
                  note_valid <= 1'b1;
                  if (!last_c) begin
                     offset   <= offset + 1'b1;
                     addr_acc <= addr_acc + STEP_W;
                     state    <= ST_WAIT_TICK;
                  end else if (loop_q) begin
                     offset   <= '0;
                     addr_acc <= base_q;
                     wrapped  <= 1'b1;
                     state    <= ST_WAIT_TICK;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DRAIN: begin
               if (rd_ack) begin
                  rd_req <= 1'b0;
                  state  <= ST_IDLE;
                  busy   <= 1'b0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               rd_req <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
